pll_phase_shift_ctrl: RTL

- Parametrised phase-shift sequencer that replaces per-PLL step processors with one controller serving N_PLL reconfigurable PLLs.
- Accepts commands from the UART data mapper: PLL index, counter select, direction and step count.
- Drives each PLL's phasestep/phasecounterselect/phaseupdown with the full phasedone handshake and a timeout.
- Adds direction control, lock supervision, per-command completion/error status and a one-deep command buffer.

---
 rtl/pll_ctrl_pkg.sv | 25 ++
 rtl/pll_phase_shift_ctrl_phasedone_sync.sv | 27 ++
 rtl/pll_phase_shift_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL phase-shift controller.
// Holds the FSM encoding, error codes and default field widths.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_STEP,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_IDX  = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam int DEF_CNT_SEL_W = 3;
    localparam int DEF_STEP_W    = 8;
    localparam int CMD_PLL_W     = 3;

endpackage

// File: rtl/pll_phase_shift_ctrl_phasedone_sync.sv
// Two-flop synchroniser for the asynchronous per-PLL phasedone lines.
// Resets to all ones, matching an idle (not shifting) PLL.
module phasedone_sync #(
    parameter int N_PLL = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_PLL-1:0] i_async,
    output logic [N_PLL-1:0] o_sync
);

    logic [N_PLL-1:0] r_meta;
    logic [N_PLL-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_phase_shift_ctrl.sv
// Single phase-shift sequencer shared by N_PLL reconfigurable PLLs.
// One-deep command buffer, phasedone handshake, lock and timeout supervision.
module pll_phase_shift_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int N_PLL     = 2,
    parameter int CNT_SEL_W = DEF_CNT_SEL_W,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int STEP_HOLD = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [CMD_PLL_W-1:0]       i_cmd_pll,
    input  logic [CNT_SEL_W-1:0]       i_cmd_cnt,
    input  logic                       i_cmd_dir,
    input  logic [STEP_W-1:0]          i_cmd_steps,
    input  logic [N_PLL-1:0]           i_locked,
    input  logic [N_PLL-1:0]           i_phasedone,
    output logic [N_PLL-1:0]           o_phasestep,
    output logic [N_PLL*CNT_SEL_W-1:0] o_phasecounterselect,
    output logic [N_PLL-1:0]           o_phaseupdown,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [1:0]                 o_err_code
);

    localparam int HOLD_W = $clog2(STEP_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_t                 r_state, w_state_next;
    logic [1:0]             w_err_next, r_err_code;
    logic                   r_buf_full;
    logic [CMD_PLL_W-1:0]   r_buf_pll, r_pll;
    logic [CNT_SEL_W-1:0]   r_buf_cnt, r_cnt;
    logic                   r_buf_dir, r_dir;
    logic [STEP_W-1:0]      r_buf_steps, r_remain;
    logic [HOLD_W-1:0]      r_hold;
    logic [TMO_W-1:0]       r_tmo;
    logic [N_PLL-1:0]       w_pd_sync;
    logic                   w_pd_sel, w_lock_sel, w_pll_ok;
    logic                   w_accept, w_load, w_step_on;
    logic [CNT_SEL_W-1:0]   r_sel [N_PLL];
    logic [N_PLL-1:0]       r_ud;

    phasedone_sync #(.N_PLL(N_PLL)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_phasedone),
        .o_sync  (w_pd_sync)
    );

    assign o_cmd_ready = !r_buf_full;
    assign w_accept    = i_cmd_valid && !r_buf_full;
    assign w_load      = (r_state == ST_IDLE) && r_buf_full;

    // Out-of-range indices select nothing, so a bad command reads as unlocked.
    always_comb begin
        w_pll_ok   = 1'b0;
        w_lock_sel = 1'b0;
        w_pd_sel   = 1'b1;
        for (int k = 0; k < N_PLL; k++) begin
            if (r_pll == CMD_PLL_W'(k)) begin
                w_pll_ok   = 1'b1;
                w_lock_sel = i_locked[k];
                w_pd_sel   = w_pd_sync[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_full  <= 1'b0;
            r_buf_pll   <= '0;
            r_buf_cnt   <= '0;
            r_buf_dir   <= 1'b0;
            r_buf_steps <= '0;
        end else begin
            if (w_load) begin
                r_buf_full <= 1'b0;
            end
            if (w_accept) begin
                r_buf_full  <= 1'b1;
                r_buf_pll   <= i_cmd_pll;
                r_buf_cnt   <= i_cmd_cnt;
                r_buf_dir   <= i_cmd_dir;
                r_buf_steps <= i_cmd_steps;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lock loss is checked first in every active state so it beats a timeout.
    always_comb begin
        w_state_next = r_state;
        w_err_next   = ERR_NONE;
        case (r_state)
            ST_IDLE: if (r_buf_full) w_state_next = ST_LOAD;
            ST_LOAD: begin
                if (!w_pll_ok) begin
                    w_state_next = ST_ERR;
                    w_err_next   = ERR_IDX;
                end else if (!w_lock_sel) begin
                    w_state_next = ST_ERR;
                    w_err_next   = ERR_LOCK;
                end else if (r_remain == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP, ST_STEP, ST_WAIT_LO, ST_WAIT_HI: begin
                if (!w_lock_sel) begin
                    w_state_next = ST_ERR;
                    w_err_next   = ERR_LOCK;
                end else if (r_state == ST_SETUP) begin
                    w_state_next = ST_STEP;
                end else if (r_state == ST_STEP) begin
                    if (r_hold == HOLD_LAST) w_state_next = ST_WAIT_LO;
                end else if (r_state == ST_WAIT_LO && !w_pd_sel) begin
                    w_state_next = ST_WAIT_HI;
                end else if (r_state == ST_WAIT_HI && w_pd_sel) begin
                    w_state_next = (r_remain == STEP_W'(1)) ? ST_DONE : ST_STEP;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = ST_ERR;
                    w_err_next   = ERR_TMO;
                end
            end
            ST_DONE, ST_ERR: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_step_on = (r_state == ST_STEP);
        o_busy    = (r_state != ST_IDLE);
        o_done    = (r_state == ST_DONE);
        o_error   = (r_state == ST_ERR);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pll      <= '0;
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_remain   <= '0;
            r_err_code <= ERR_NONE;
            r_hold     <= '0;
            r_tmo      <= '0;
        end else begin
            if (w_load) begin
                r_pll      <= r_buf_pll;
                r_cnt      <= r_buf_cnt;
                r_dir      <= r_buf_dir;
                r_remain   <= r_buf_steps;
                r_err_code <= ERR_NONE;
            end else if (w_state_next == ST_ERR) begin
                r_remain   <= '0;
                r_err_code <= w_err_next;
            end else if (r_state == ST_WAIT_HI && w_state_next != ST_WAIT_HI) begin
                r_remain <= r_remain - STEP_W'(1);
            end
            r_hold <= (r_state == ST_STEP) ? r_hold + HOLD_W'(1) : '0;
            if (w_state_next != r_state) begin
                r_tmo <= '0;
            end else if (r_state == ST_WAIT_LO || r_state == ST_WAIT_HI) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    assign o_err_code = r_err_code;

    generate
        for (genvar gi = 0; gi < N_PLL; gi++) begin : g_pll
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sel[gi] <= '0;
                    r_ud[gi]  <= 1'b1;
                end else if (r_state == ST_LOAD && w_state_next == ST_SETUP &&
                             r_pll == CMD_PLL_W'(gi)) begin
                    r_sel[gi] <= r_cnt;
                    r_ud[gi]  <= r_dir;
                end
            end
            assign o_phasecounterselect[gi*CNT_SEL_W +: CNT_SEL_W] = r_sel[gi];
            assign o_phaseupdown[gi] = r_ud[gi];
            assign o_phasestep[gi]   = w_step_on && (r_pll == CMD_PLL_W'(gi)) && i_locked[gi];
        end
    endgenerate

endmodule
